// File: rtl/issue_controller_pkg.sv
// Shared types and defaults for the in-order issue controller.
package issue_controller_pkg;

  localparam int unsigned REG_IDX_W_DEFAULT    = 5;
  localparam int unsigned MAX_INFLIGHT_DEFAULT = 4;

  // Scheduler state: normal issue, waiting for in-flight ops before a trap,
  // and holding the trap request until the handler acknowledges it.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } sched_state_e;

  typedef enum logic {
    CAUSE_ECALL   = 1'b0,
    CAUSE_ILLEGAL = 1'b1
  } trap_cause_e;

  // An unsupported encoding outranks ecall when both are flagged.
  function automatic trap_cause_e select_cause(input logic unsupported);
    if (unsupported) begin
      return CAUSE_ILLEGAL;
    end else begin
      return CAUSE_ECALL;
    end
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy bits. A set and a clear of the same register in one
// cycle resolve to set; register 0 is hard-wired not busy.
module issue_scoreboard
  import issue_controller_pkg::*;
#(
  parameter int REG_IDX_W = REG_IDX_W_DEFAULT,
  localparam int NUM_REGS = 2 ** REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;

  // Next busy vector: clear first so a same-cycle set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Busy-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/issue_controller.sv
// In-order issue controller: stalls on RAW/WAW hazards, in-flight limit and
// a single long-latency unit; drains and raises a trap on ecall/illegal ops.
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int REG_IDX_W    = REG_IDX_W_DEFAULT,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1),
  localparam int NUM_REGS    = 2 ** REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_uses_rs2,
  input  logic                 dec_regwr,
  input  logic                 dec_long,
  input  logic                 dec_ecall,
  input  logic                 dec_unsupported,
  output logic                 iss_valid,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_long,
  output logic                 trap_req,
  output logic                 trap_cause,
  input  logic                 trap_ack,
  output logic [CNT_W-1:0]     inflight,
  output logic [NUM_REGS-1:0]  busy_vec
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  sched_state_e        state_d, state_q;
  trap_cause_e         cause_d, cause_q;
  logic [CNT_W-1:0]    inflight_d, inflight_q;
  logic                long_busy_d, long_busy_q;

  logic [NUM_REGS-1:0] busy_bits;
  logic                hazard;
  logic                cap_ok;
  logic                long_ok;
  logic                trap_op;
  logic                issue_wr;
  logic                wb_take;

  issue_scoreboard #(
    .REG_IDX_W (REG_IDX_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue_wr),
    .set_idx (dec_rd),
    .clr_en  (wb_take),
    .clr_idx (wb_rd),
    .busy    (busy_bits)
  );

  // Issue conditions, judged against registered state only (no wb bypass).
  always_comb begin
    hazard  = busy_bits[dec_rs1]
            | (dec_uses_rs2 & busy_bits[dec_rs2])
            | (dec_regwr & busy_bits[dec_rd]);
    cap_ok  = (inflight_q < MAX_CNT) | ~dec_regwr;
    long_ok = ~(dec_long & long_busy_q);
    trap_op = dec_valid & (dec_ecall | dec_unsupported);
  end

  // Scheduler next state, handshake and trap outputs.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    dec_ready = 1'b0;
    trap_req  = 1'b0;
    if (reset) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (trap_op) begin
            state_d = DRAIN;
            cause_d = select_cause(dec_unsupported);
          end else begin
            dec_ready = ~hazard & cap_ok & long_ok;
          end
        end
        DRAIN: begin
          if ((inflight_q == '0) && !long_busy_q) begin
            state_d = TRAP;
          end else begin
            state_d = DRAIN;
          end
        end
        TRAP: begin
          trap_req  = 1'b1;
          dec_ready = trap_ack;
          if (trap_ack) begin
            state_d = RUN;
          end else begin
            state_d = TRAP;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Issue is combinational so a ready instruction leaves in the same cycle.
  always_comb begin
    iss_valid = dec_valid & dec_ready & (state_q == RUN) & ~dec_ecall
              & ~dec_unsupported & ~reset;
    issue_wr  = iss_valid & dec_regwr & (dec_rd != '0);
    wb_take   = wb_valid & (inflight_q != '0);
  end

  // In-flight counter and long-unit occupancy; issue outranks writeback.
  always_comb begin
    case ({issue_wr, wb_take})
      2'b10:   inflight_d = inflight_q + ONE_CNT;
      2'b01:   inflight_d = inflight_q - ONE_CNT;
      default: inflight_d = inflight_q;
    endcase
    if (iss_valid && dec_long) begin
      long_busy_d = 1'b1;
    end else if (wb_valid && wb_long) begin
      long_busy_d = 1'b0;
    end else begin
      long_busy_d = long_busy_q;
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cause_q     <= CAUSE_ECALL;
      inflight_q  <= '0;
      long_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      inflight_q  <= inflight_d;
      long_busy_q <= long_busy_d;
    end
  end

  assign trap_cause = cause_q;
  assign inflight   = inflight_q;
  assign busy_vec   = busy_bits;

endmodule
